// File: rtl/pwm_compare_dt_16bits_pkg.sv
// ---------------------------------------------------------------------------
// pwm_compare_dt_16bits_pkg
//   Shared types and widths for the PWM compare / dead-time stage.
//   - PWMCOUNT_WIDTH : width of the carrier and compare values
//   - DEADTIME_WIDTH : default width of the dead-time counter
//   - pwm_onoff_t    : global PWM enable
//   - dt_state_t     : dead-time FSM state encoding
// ---------------------------------------------------------------------------
package pwm_compare_dt_16bits_pkg;

    localparam int PWMCOUNT_WIDTH = 16;
    localparam int DEADTIME_WIDTH = 10;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } pwm_onoff_t;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LOW   = 3'd1,
        S_DT_LH = 3'd2,
        S_HIGH  = 3'd3,
        S_DT_HL = 3'd4
    } dt_state_t;

endpackage

// File: rtl/pwm_compare_dt_16bits_deadtime_fsm.sv
// ---------------------------------------------------------------------------
// pwm_compare_dt_16bits_deadtime_fsm
//   Gate-drive state machine: turns the registered compare reference into a
//   complementary high/low gate pair, inserting a dead-time gap on every
//   edge when PWM_DEADTIME_EN is defined. Without the macro the dead-time
//   states and counter do not exist and the gates follow the reference with
//   one cycle of delay.
//
//   Ports:
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     enable_i     global PWM enable (1 = ON)
//     trip_i       synchronous fault, forces S_OFF next edge
//     tripped_i    sticky fault status, blocks leaving S_OFF
//     ref_i        registered (carrier < compare) reference
//     deadtime_i   shadowed dead-time in clk cycles (PWM_DEADTIME_EN only)
//     pwm_h_o      high-side gate
//     pwm_l_o      low-side gate
//     dt_active_o  high while a dead-time interval runs
//
//   Configuration macro: PWM_DEADTIME_EN
// ---------------------------------------------------------------------------
module pwm_compare_dt_16bits_deadtime_fsm
    import pwm_compare_dt_16bits_pkg::*;
#(
    parameter int DT_WIDTH = DEADTIME_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic                trip_i,
    input  logic                tripped_i,
    input  logic                ref_i,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_WIDTH-1:0] deadtime_i,
`endif
    output logic                pwm_h_o,
    output logic                pwm_l_o,
    output logic                dt_active_o
);

    dt_state_t state_q, state_d;
    logic      pwm_h_q;
    logic      pwm_l_q;

`ifdef PWM_DEADTIME_EN
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                dt_zero;
    logic                dt_active_q;

    // A zero dead-time skips the gap states entirely so the gates swap
    // on the same edge; this also keeps the counter from ever wrapping.
    assign dt_zero = (deadtime_i == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (trip_i || !enable_i) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (!tripped_i) begin
                        if (!ref_i) begin
                            state_d = S_LOW;
                        end else if (dt_zero) begin
                            state_d = S_HIGH;
                        end else begin
                            state_d = S_DT_LH;
                            cnt_d   = deadtime_i;
                        end
                    end
                end
                S_LOW: begin
                    if (ref_i) begin
                        if (dt_zero) begin
                            state_d = S_HIGH;
                        end else begin
                            state_d = S_DT_LH;
                            cnt_d   = deadtime_i;
                        end
                    end
                end
                S_DT_LH: begin
                    // Reference falling back first aborts the edge: pulses
                    // shorter than the dead-time never reach the gate.
                    if (!ref_i) begin
                        state_d = S_LOW;
                    end else if (cnt_q <= DT_WIDTH'(1)) begin
                        state_d = S_HIGH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!ref_i) begin
                        if (dt_zero) begin
                            state_d = S_LOW;
                        end else begin
                            state_d = S_DT_HL;
                            cnt_d   = deadtime_i;
                        end
                    end
                end
                S_DT_HL: begin
                    if (ref_i) begin
                        state_d = S_HIGH;
                    end else if (cnt_q <= DT_WIDTH'(1)) begin
                        state_d = S_LOW;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwm_h_q     <= (state_d == S_HIGH);
            pwm_l_q     <= (state_d == S_LOW);
            dt_active_q <= (state_d == S_DT_LH) || (state_d == S_DT_HL);
        end
    end

    assign dt_active_o = dt_active_q;
`else
    always_comb begin
        state_d = state_q;
        if (trip_i || !enable_i) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (!tripped_i) begin
                        state_d = ref_i ? S_HIGH : S_LOW;
                    end
                end
                default: state_d = ref_i ? S_HIGH : S_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pwm_h_q <= (state_d == S_HIGH);
            pwm_l_q <= (state_d == S_LOW);
        end
    end

    assign dt_active_o = 1'b0;
`endif

    assign pwm_h_o = pwm_h_q;
    assign pwm_l_o = pwm_l_q;

endmodule

// File: rtl/pwm_compare_dt_16bits.sv
// ---------------------------------------------------------------------------
// pwm_compare_dt_16bits
//   One PWM phase leg behind a 16-bit carrier: shadows the compare (and
//   dead-time) values, compares them against the carrier and drives a
//   complementary gate pair through the dead-time FSM. Shadows load every
//   cycle while PWM is OFF and only on maskevent while ON, so duty changes
//   land at carrier peaks/valleys.
//
//   Ports:
//     clk        system clock (same clock as the carrier block)
//     reset      asynchronous active-low reset
//     carrier    carrier value from the upstream stage
//     maskevent  single-cycle shadow-load strobe
//     compare    duty compare value
//     deadtime   dead-time in clk cycles (ignored without PWM_DEADTIME_EN)
//     pwm_onoff  global enable
//     trip       synchronous fault, forces both gates inactive
//     pwm_h      high-side gate, active-high
//     pwm_l      low-side gate, active-high
//     dt_active  high while a dead-time interval runs
//     tripped    sticky fault status, cleared only while pwm_onoff = OFF
//
//   Configuration macro: PWM_DEADTIME_EN (defined = dead-time insertion)
// ---------------------------------------------------------------------------
module pwm_compare_dt_16bits
    import pwm_compare_dt_16bits_pkg::*;
#(
    parameter int DT_WIDTH = DEADTIME_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PWMCOUNT_WIDTH-1:0] carrier,
    input  logic                      maskevent,
    input  logic [15:0]               compare,
    input  logic [DT_WIDTH-1:0]       deadtime,
    input  pwm_onoff_t                pwm_onoff,
    input  logic                      trip,
    output logic                      pwm_h,
    output logic                      pwm_l,
    output logic                      dt_active,
    output logic                      tripped
);

    logic [15:0] compare_m_q;
    logic        ref_q, ref_d;
    logic        tripped_q, tripped_d;
    logic        enable;
    logic        load_shadow;

    assign enable      = (pwm_onoff == PWM_ON);
    assign load_shadow = !enable || maskevent;

    // compare_m = 0 never lets the reference rise; compare_m above the
    // carrier period keeps it high for the whole period.
    assign ref_d = (carrier < compare_m_q);

    // Trip wins over the OFF-clear so a fault held during OFF stays visible.
    assign tripped_d = trip ? 1'b1 : (!enable ? 1'b0 : tripped_q);

`ifdef PWM_DEADTIME_EN
    logic [DT_WIDTH-1:0] deadtime_m_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deadtime_m_q <= '0;
        end else if (load_shadow) begin
            deadtime_m_q <= deadtime;
        end
    end
`else
    logic unused_deadtime;
    assign unused_deadtime = ^deadtime;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            compare_m_q <= '0;
            ref_q       <= 1'b0;
            tripped_q   <= 1'b0;
        end else begin
            if (load_shadow) begin
                compare_m_q <= compare;
            end
            ref_q     <= ref_d;
            tripped_q <= tripped_d;
        end
    end

    pwm_compare_dt_16bits_deadtime_fsm #(
        .DT_WIDTH (DT_WIDTH)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (reset),
        .enable_i    (enable),
        .trip_i      (trip),
        .tripped_i   (tripped_q),
        .ref_i       (ref_q),
`ifdef PWM_DEADTIME_EN
        .deadtime_i  (deadtime_m_q),
`endif
        .pwm_h_o     (pwm_h),
        .pwm_l_o     (pwm_l),
        .dt_active_o (dt_active)
    );

    assign tripped = tripped_q;

endmodule

// File: tb/tb_pwm_compare_dt_16bits.sv
// ---------------------------------------------------------------------------
// tb_pwm_compare_dt_16bits
//   Directed bench for pwm_compare_dt_16bits. The carrier is driven directly
//   so every crossing cycle is known exactly. Observed outputs are packed as
//   {pwm_h, pwm_l, dt_active, tripped}. Expected dead-time gaps follow the
//   build: with PWM_DEADTIME_EN the programmed value, otherwise zero.
// ---------------------------------------------------------------------------
module tb_pwm_compare_dt_16bits;
    import pwm_compare_dt_16bits_pkg::*;

`ifdef PWM_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] carrier;
    logic        maskevent;
    logic [15:0] compare;
    logic [9:0]  deadtime;
    pwm_onoff_t  pwm_onoff;
    logic        trip;
    logic        pwm_h;
    logic        pwm_l;
    logic        dt_active;
    logic        tripped;
    logic [3:0]  obs;

    int tests = 0;
    int fails = 0;

    assign obs = {pwm_h, pwm_l, dt_active, tripped};

    always #5 clk = ~clk;

    pwm_compare_dt_16bits #(
        .DT_WIDTH (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .carrier   (carrier),
        .maskevent (maskevent),
        .compare   (compare),
        .deadtime  (deadtime),
        .pwm_onoff (pwm_onoff),
        .trip      (trip),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l),
        .dt_active (dt_active),
        .tripped   (tripped)
    );

    // Advance one active edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus causing the crossing has just been applied. n+1: gates
    // unchanged; n+2 .. n+1+gap: dead-time; n+2+gap: incoming gate high.
    task automatic test_transition(input string name, input bit to_high, input int gap);
        logic [3:0] prev_v;
        logic [3:0] next_v;
        prev_v = to_high ? 4'b0100 : 4'b1000;
        next_v = to_high ? 4'b1000 : 4'b0100;
        step();
        tests++;
        if (obs !== prev_v) begin
            fails++;
            $display("FAIL %s n+1: got %b want %b", name, obs, prev_v);
        end
        step();
        for (int k = 0; k < gap; k++) begin
            tests++;
            if (obs !== 4'b0010) begin
                fails++;
                $display("FAIL %s gap%0d: got %b want 0010", name, k, obs);
            end
            step();
        end
        tests++;
        if (obs !== next_v) begin
            fails++;
            $display("FAIL %s settle: got %b want %b", name, obs, next_v);
        end
        $display("[TB] %s: transition to_high=%0d gap=%0d checked", name, to_high, gap);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        carrier   = 16'd100;
        maskevent = 1'b0;
        compare   = 16'd50;
        deadtime  = 10'd5;
        pwm_onoff = PWM_OFF;
        trip      = 1'b0;
        step();
        step();
        tests++;
        if (obs !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold: got %b want 0000", obs);
        end
        reset = 1'b1;
        step();
        step();
        tests++;
        if (obs !== 4'b0000) begin
            fails++;
            $display("FAIL reset_off: got %b want 0000", obs);
        end
        $display("[TB] reset: outputs idle");
    endtask

    task automatic test_enable();
        pwm_onoff = PWM_ON;
        step();
        tests++;
        if (obs !== 4'b0100) begin
            fails++;
            $display("FAIL enable_low: got %b want 0100", obs);
        end
        step();
        tests++;
        if (obs !== 4'b0100) begin
            fails++;
            $display("FAIL enable_hold: got %b want 0100", obs);
        end
        $display("[TB] enable: S_LOW entered");
    endtask

    // Boundary crossings: 49 < 50 raises the reference, 50 < 50 does not.
    task automatic test_deadtime_edges();
        carrier = 16'd49;
        test_transition("rise49", 1'b1, DT_EN ? 5 : 0);
        step();
        step();
        tests++;
        if (obs !== 4'b1000) begin
            fails++;
            $display("FAIL high_hold: got %b want 1000", obs);
        end
        carrier = 16'd50;
        test_transition("fall50", 1'b0, DT_EN ? 5 : 0);
    endtask

    task automatic test_short_pulse();
        logic       pulse;
        logic [3:0] exp_v;
        deadtime  = 10'd10;
        maskevent = 1'b1;
        step();
        maskevent = 1'b0;
        step();
        tests++;
        if (obs !== 4'b0100) begin
            fails++;
            $display("FAIL short_pre: got %b want 0100", obs);
        end
        carrier = 16'd40;
        for (int m = 1; m <= 8; m++) begin
            step();
            if (m == 4) carrier = 16'd50;
            pulse = (m >= 2) && (m <= 5);
            exp_v = {DT_EN ? 1'b0 : pulse, !pulse, DT_EN ? pulse : 1'b0, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL short_m%0d: got %b want %b", m, obs, exp_v);
            end
        end
        $display("[TB] short pulse: 4-cycle reference pulse checked");
    endtask

    task automatic test_shadow_load();
        compare  = 16'd80;
        deadtime = 10'd3;
        carrier  = 16'd60;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (obs !== 4'b0100) begin
                fails++;
                $display("FAIL shadow_hold%0d: got %b want 0100", i, obs);
            end
        end
        maskevent = 1'b1;
        step();
        maskevent = 1'b0;
        tests++;
        if (obs !== 4'b0100) begin
            fails++;
            $display("FAIL shadow_mask: got %b want 0100", obs);
        end
        test_transition("shadow80", 1'b1, DT_EN ? 3 : 0);

        compare   = 16'd0;
        maskevent = 1'b1;
        step();
        maskevent = 1'b0;
        test_transition("compare0", 1'b0, DT_EN ? 3 : 0);
        for (int i = 0; i < 3; i++) begin
            carrier = (i == 0) ? 16'd0 : ((i == 1) ? 16'd1 : 16'hFFFF);
            step();
            step();
            tests++;
            if (obs !== 4'b0100) begin
                fails++;
                $display("FAIL compare0_c%0d: got %b want 0100", carrier, obs);
            end
        end
    endtask

    task automatic test_trip();
        compare   = 16'd80;
        carrier   = 16'd60;
        maskevent = 1'b1;
        step();
        maskevent = 1'b0;
        test_transition("trip_setup", 1'b1, DT_EN ? 3 : 0);
        trip = 1'b1;
        step();
        trip = 1'b0;
        tests++;
        if (obs !== 4'b0001) begin
            fails++;
            $display("FAIL trip_now: got %b want 0001", obs);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (obs !== 4'b0001) begin
                fails++;
                $display("FAIL trip_stay%0d: got %b want 0001", i, obs);
            end
        end
        pwm_onoff = PWM_OFF;
        step();
        tests++;
        if (obs !== 4'b0000) begin
            fails++;
            $display("FAIL trip_clear: got %b want 0000", obs);
        end
        pwm_onoff = PWM_ON;
        step();
        for (int k = 0; k < (DT_EN ? 3 : 0); k++) begin
            tests++;
            if (obs !== 4'b0010) begin
                fails++;
                $display("FAIL resume_gap%0d: got %b want 0010", k, obs);
            end
            step();
        end
        tests++;
        if (obs !== 4'b1000) begin
            fails++;
            $display("FAIL resume_high: got %b want 1000", obs);
        end
        $display("[TB] trip: fault, hold, clear and resume checked");
    endtask

    task automatic test_reset_mid_dt();
        logic [3:0] before_v;
        carrier = 16'd90;
        step();
        step();
        before_v = DT_EN ? 4'b0010 : 4'b0100;
        tests++;
        if (obs !== before_v) begin
            fails++;
            $display("FAIL pre_reset: got %b want %b", obs, before_v);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (obs !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset: got %b want 0000", obs);
        end
        pwm_onoff = PWM_OFF;
        reset     = 1'b1;
        step();
        tests++;
        if (obs !== 4'b0000) begin
            fails++;
            $display("FAIL post_reset_off: got %b want 0000", obs);
        end
        pwm_onoff = PWM_ON;
        step();
        tests++;
        if (obs !== 4'b0100) begin
            fails++;
            $display("FAIL post_reset_on: got %b want 0100", obs);
        end
        $display("[TB] reset mid-interval: outputs cleared asynchronously");
    endtask

    initial begin
        test_reset();
        test_enable();
        test_deadtime_edges();
        test_short_pulse();
        test_shadow_load();
        test_trip();
        test_reset_mid_dt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
